// File: rtl/dram_responder.sv
// dram_responder: in-order data RAM responder with split addr_ok/data_ok
// handshake, byte-strobed writes and fixed-latency raw read words.
module dram_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int DW = DEPTH_LOG2;
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  logic [31:0]   mem    [2**DW];
  logic          q_wr   [QDEPTH];
  logic [3:0]    q_strb [QDEPTH];
  logic [DW-1:0] q_idx  [QDEPTH];
  logic [31:0]   q_data [QDEPTH];
  logic [2:0]    q_age  [QDEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          push;
  logic          pop;
  logic          unused;

  assign unused  = ^{addr[31:DW+2], addr[1:0]};
  assign addr_ok = resetn && (count < QFULL);
  assign push    = req && addr_ok;
  // age is sampled pre-increment, so +1 makes acceptance at E retire at E+LATENCY
  assign pop     = (count != '0) &&
                   (({1'b0, q_age[head]} + 4'd1) >= LAT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      data_ok <= 1'b0;
      rdata   <= '0;
      for (int i = 0; i < QDEPTH; i++) q_age[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++)
        if (q_age[i] != 3'd7) q_age[i] <= q_age[i] + 3'd1;
      if (push) begin
        q_age[tail] <= '0;
        tail        <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      data_ok <= pop;
      if (pop) rdata <= q_wr[head] ? 32'h0 : mem[q_idx[head]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_wr[tail]   <= wr;
      q_strb[tail] <= wstrb;
      q_idx[tail]  <= addr[DW+1:2];
      q_data[tail] <= wdata;
    end
    if (pop && q_wr[head])
      for (int b = 0; b < 4; b++)
        if (q_strb[head][b])
          mem[q_idx[head]][8*b +: 8] <= q_data[head][8*b +: 8];
  end

endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: reference-model, table and corner-case bench for
// dram_responder (LATENCY=2 main instance, LATENCY=7 queue-full instance).
module tb_dram_responder;
  localparam int L  = 2;
  localparam int LB = 7;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        reqb = 1'b0;
  logic        addr_okb;
  logic        data_okb;
  logic [31:0] rdatab;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  dram_responder #(.DEPTH_LOG2(10), .LATENCY(L), .QDEPTH(QD)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata)
  );

  dram_responder #(.DEPTH_LOG2(10), .LATENCY(LB), .QDEPTH(QD)) dutb (
    .clk(clk), .resetn(resetn), .req(reqb), .wr(1'b0), .wstrb(4'h0),
    .addr(32'h0), .wdata(32'h0), .addr_ok(addr_okb), .data_ok(data_okb),
    .rdata(rdatab)
  );

  typedef struct {
    int          acc;
    logic        w;
    logic [3:0]  s;
    int          idx;
    logic [31:0] d;
  } mreq_t;

  typedef struct {
    int          e;
    logic [31:0] d;
  } resp_t;

  typedef struct {
    logic        w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  mreq_t       mq[$];
  resp_t       rlog[$];
  logic [31:0] mm [1024];
  int          last_ret = -100;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: check the responses of the last edge, then drive new inputs.
  task automatic tick(input logic r, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d,
                      output int acc_e);
    int          k;
    int          rt;
    logic        eok;
    logic [31:0] erd;
    mreq_t       h;
    @(negedge clk);
    k = edge_cnt;
    eok = 1'b0;
    erd = 32'h0;
    if (mq.size() > 0) begin
      rt = mq[0].acc + L;
      if (last_ret + 1 > rt) rt = last_ret + 1;
      if (rt <= k) begin
        h = mq.pop_front();
        eok = 1'b1;
        last_ret = k;
        if (h.w) begin
          for (int b = 0; b < 4; b++)
            if (h.s[b]) mm[h.idx][8*b +: 8] = h.d[8*b +: 8];
        end else begin
          erd = mm[h.idx];
        end
      end
    end
    chk("data_ok", 32'(data_ok), 32'(eok));
    if (data_ok) rlog.push_back('{k, rdata});
    if (eok && data_ok) chk("rdata", rdata, erd);
    chk("addr_ok", 32'(addr_ok), 32'(mq.size() < QD));
    req = r; wr = w; wstrb = s; addr = a; wdata = d;
    acc_e = -1;
    if (r && mq.size() < QD) begin
      mq.push_back('{k + 1, w, s, int'((a >> 2) % 1024), d});
      acc_e = k + 1;
    end
  endtask

  task automatic idle(input int n);
    int e;
    repeat (n) tick(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, e);
  endtask

  task automatic wrt(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    int e;
    tick(1'b1, 1'b1, s, a, d, e);
  endtask

  task automatic rd(input logic [31:0] a);
    int e;
    tick(1'b1, 1'b0, 4'h0, a, 32'h0, e);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    resetn = 1'b0;
    req = 1'b0;
    reqb = 1'b0;
    mq.delete();
    last_ret = -100;
    repeat (n) begin
      @(negedge clk);
      chk("rst_addr_ok", 32'(addr_ok), 32'h0);
      chk("rst_data_ok", 32'(data_ok), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_b_data_ok", 32'(data_okb), 32'h0);
    end
    resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t tv[12];
    int   ae[4];
    int   bq[$];
    int   k, rt, lastb, accb, okb, e;
    logic eokb;
    logic [31:0] a;

    tv[0]  = '{1'b1, 4'hF, 32'h80,       32'hAAAAAAAA, 32'h0};
    tv[1]  = '{1'b0, 4'h0, 32'h80,       32'h0,        32'hAAAAAAAA};
    tv[2]  = '{1'b1, 4'hF, 32'h80,       32'h55555555, 32'h0};
    tv[3]  = '{1'b0, 4'h0, 32'h80,       32'h0,        32'h55555555};
    tv[4]  = '{1'b1, 4'h0, 32'h40,       32'hFFFFFFFF, 32'h0};
    tv[5]  = '{1'b0, 4'h0, 32'h40,       32'h0,        32'hFF34FFFF};
    tv[6]  = '{1'b1, 4'h9, 32'h1040,     32'hA1B2C3D4, 32'h0};
    tv[7]  = '{1'b0, 4'h0, 32'h43,       32'h0,        32'hA134FFD4};
    tv[8]  = '{1'b1, 4'h6, 32'h80,       32'h12345678, 32'h0};
    tv[9]  = '{1'b0, 4'h0, 32'h80,       32'h0,        32'h55345655};
    tv[10] = '{1'b1, 4'hF, 32'hFFFFF084, 32'hCAFEF00D, 32'h0};
    tv[11] = '{1'b0, 4'h0, 32'h84,       32'h0,        32'hCAFEF00D};

    // reset then idle
    do_reset(3);
    idle(3);
    chk("idle_rdata", rdata, 32'h0);

    // byte-lane merge with a one-cycle gap before the read
    rlog.delete();
    wrt(32'h40, 32'hFFFFFFFF, 4'hF);
    wrt(32'h40, 32'h12345678, 4'h4);
    idle(1);
    rd(32'h40);
    idle(6);
    chk("lane_resp_cnt", 32'(rlog.size()), 32'd3);
    if (rlog.size() == 3) begin
      chk("lane_gap", 32'(rlog[2].e - rlog[1].e), 32'd2);
      chk("lane_rdata", rlog[2].d, 32'hFF34FFFF);
    end

    // back-to-back reads: fixed latency, one response per cycle
    rlog.delete();
    for (int i = 0; i < 4; i++)
      tick(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, ae[i]);
    idle(6);
    chk("b2b_resp_cnt", 32'(rlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < rlog.size(); i++)
      chk("b2b_latency", 32'(rlog[i].e), 32'(ae[i] + L));

    // table: ordering, zero strobe, aliasing, partial strobes
    rlog.delete();
    for (int i = 0; i < 12; i++)
      tick(1'b1, tv[i].w, tv[i].s, tv[i].a, tv[i].d, e);
    idle(6);
    chk("tbl_resp_cnt", 32'(rlog.size()), 32'd12);
    for (int i = 0; i < 12 && i < rlog.size(); i++)
      chk($sformatf("tbl_vec%0d", i), rlog[i].d, tv[i].exp);

    // queue-full behaviour on the LATENCY=7 instance
    accb = 0;
    okb = 0;
    lastb = -100;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      k = edge_cnt;
      eokb = 1'b0;
      if (bq.size() > 0) begin
        rt = bq[0] + LB;
        if (lastb + 1 > rt) rt = lastb + 1;
        if (rt <= k) begin
          void'(bq.pop_front());
          eokb = 1'b1;
          lastb = k;
        end
      end
      chk("b_data_ok", 32'(data_okb), 32'(eokb));
      chk("b_addr_ok", 32'(addr_okb), 32'(bq.size() < QD));
      if (data_okb) okb++;
      if (n >= 4 && n <= 7) chk("b_full_stall", 32'(addr_okb), 32'h0);
      if (n == 8) chk("b_first_resp", 32'(data_okb), 32'h1);
      reqb = (n < 20);
      if (reqb && addr_okb) begin
        accb++;
        bq.push_back(k + 1);
      end
    end
    chk("b_resp_count", okb, accb);

    // randomized traffic over a small aliased word set
    for (int i = 0; i < 8; i++)
      wrt(32'((128 + i) << 2), $urandom, 4'hF);
    for (int i = 0; i < 400; i++) begin
      a = ($urandom & 32'hFFFFF000) |
          (32'(128 + $urandom_range(0, 7)) << 2) |
          32'($urandom_range(0, 3));
      tick(($urandom % 4) != 0, 1'($urandom), 4'($urandom), a, $urandom, e);
    end
    idle(10);
    chk("rand_drain", 32'(mq.size()), 32'h0);

    // reset while a write is still queued
    wrt(32'h100, 32'h11223344, 4'hF);
    idle(4);
    wrt(32'h100, 32'hDEADBEEF, 4'hF);
    do_reset(3);
    idle(3);
    rlog.delete();
    rd(32'h100);
    idle(4);
    chk("rst_drop_cnt", 32'(rlog.size()), 32'd1);
    if (rlog.size() == 1) chk("rst_drop_rdata", rlog[0].d, 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Memory-side responder for the core's data port: the other end of the load/store path that produces byte strobes and consumes raw load words.
- Accepts word-aligned read/write requests with 4-bit byte strobes over an addr_ok/data_ok split handshake.
- Holds requests in an in-order queue, commits writes byte-wise, and returns raw 32-bit read words after a fixed latency.
- Used as the data RAM model in simulation and as the on-chip data RAM in synthesis builds.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words; word index = addr[DEPTH_LOG2+1:2].
- LATENCY, 2, minimum edges from acceptance to response; legal range 1..7.
- QDEPTH, 4, request queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- wstrb  in  4  byte enables for writes (bit i = byte lane i); ignored for reads.
- addr  in  32  byte address; addr[1:0] ignored; upper bits above the index ignored (aliasing).
- wdata  in  32  write data, lane-aligned.
- addr_ok  out  1  request accepted this cycle when req && addr_ok.
- data_ok  out  1  one-cycle response pulse, one per accepted request, in acceptance order.
- rdata  out  32  read word, valid while data_ok=1 for a read; 0 for write responses.

Behaviour:
- Reset is asynchronous and active-low; clock is clk, reset is resetn. While resetn=0:
  - queue empty, all age counters 0;
  - data_ok=0, rdata=0, addr_ok=0;
  - RAM contents are not reset.
- addr_ok is combinational: resetn && (count < QDEPTH).
  - It ignores a same-cycle pop, so a full queue never accepts, even on a retire edge.
- Accept at edge E when req && addr_ok:
  - push {wr, wstrb, index, wdata} at the tail with age=0;
  - the requester may change req/addr/wdata in the cycle after E.
- Each edge, every valid entry's 3-bit age increments, saturating at 7.
- Retire:
  - The head retires at the first edge where head age >= LATENCY.
  - At most one retirement per edge, strictly in order.
  - A request accepted at edge E retires at edge E+LATENCY if the queue ahead of it is empty; otherwise it retires one edge after its predecessor.
- Retire of a write:
  - for each i with wstrb[i]=1, mem[index][8i+7:8i] <= wdata[8i+7:8i]; other lanes are unchanged;
  - wstrb=0000 is acknowledged with no memory change;
  - any strobe pattern is committed as given, with no legality check;
  - registered data_ok=1 and rdata=0 in the cycle after the retire edge.
- Retire of a read:
  - registered rdata <= mem[index], reflecting all writes retired at earlier edges;
  - data_ok=1 in the cycle after the retire edge.
- With no retire at an edge, data_ok <= 0 and rdata holds its last value.
  - Bench checks rdata only while data_ok=1.
- Ordering: commit happens at retire, not at accept.
  - A read accepted before a write to the same word returns the old data.
  - A read accepted after it returns the new data.
- Push and pop on the same edge: both occur and count is unchanged.
  - The newly pushed entry starts at age 0; the popped entry leaves.
- Queue pointers are log2(QDEPTH)-bit and wrap naturally; count is log2(QDEPTH)+1 bits.
- Reset mid-operation: all pending requests are discarded with no response. Any write not yet retired does not modify the RAM.
- Throughput: with a full pipeline, one response per cycle sustained.

Test Plan:
- Reset then idle: resetn low for 3 cycles, then high, no req -> addr_ok=1 after release, data_ok stays 0, rdata=0.
- Byte-lane write: write addr 0x40, wdata 0xFFFFFFFF, wstrb 1111; then write 0x12345678 with wstrb 0100; then read 0x40 (LATENCY=2) -> read data_ok exactly 2 cycles after the second write's data_ok; rdata=0xFF34FFFF.
- Latency and back-to-back: 4 reads on consecutive cycles accepted at edges 0..3 -> data_ok high in the cycles after edges 2,3,4,5; the data_ok count equals the accept count.
- Full queue: QDEPTH=4, LATENCY=7, req held high -> 4 accepts, then addr_ok=0 until after the first retire edge; no request is lost or duplicated.
- Ordering: read 0x80 (old=0xAAAAAAAA), then write 0x80=0x55555555 wstrb 1111, then read 0x80 -> responses R, W, R with rdata 0xAAAAAAAA, 0, 0x55555555.
- Reset mid-flight: accept write 0x100=0xDEADBEEF, assert resetn low before it retires, release, then read 0x100 -> pre-reset value returned; no data_ok during or after reset for the dropped write.
